// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the MEM-stage memory port arbiter.
// The optional statistics counters are enabled with MEM_ARB_STATS_EN.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_EXT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating stall-cycle and external-grant counters for the memory port arbiter.
// Instantiated only when MEM_ARB_STATS_EN is defined.
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              core_stall,
    input  logic              ext_gnt,
    output logic [STAT_W-1:0] stat_stall_cnt,
    output logic [STAT_W-1:0] stat_ext_cnt
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] ext_cnt_q, ext_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        if (core_stall && (stall_cnt_q != STAT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
        if (ext_gnt && (ext_cnt_q != STAT_MAX)) begin
            ext_cnt_d = ext_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            ext_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
        end
    end

    assign stat_stall_cnt = stall_cnt_q;
    assign stat_ext_cnt   = ext_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported MEM-stage data memory between the pipeline and an external
// requester; fixed-latency transactions, starvation guard. Stats via MEM_ARB_STATS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no access in flight; arbitrate core vs. external request
// BUSY_CORE | core access in flight, waiting MEM_LAT cycles for data
// BUSY_EXT  | external access in flight, waiting MEM_LAT cycles for data
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_memread,
    input  logic              core_memwrite,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_stall_cnt,
    output logic [STAT_W-1:0] stat_ext_cnt
`endif
);

    localparam int LAT_W    = 3;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wr_q, wr_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
    logic                core_done_q, core_done_d;
    logic                ext_gnt_q, ext_gnt_d;
    logic                ext_rvalid_q, ext_rvalid_d;

    logic core_req;
    logic starve_full;

    // In the core_done cycle the pipeline advances, so the request still on the bus is stale.
    assign core_req    = (core_memread | core_memwrite) & ~core_done_q;
    assign starve_full = (starve_q == STARVE_W'(STARVE_MAX));

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        starve_d     = starve_q;
        wr_d         = wr_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        ext_rdata_d  = ext_rdata_q;
        core_done_d  = 1'b0;
        ext_gnt_d    = 1'b0;
        ext_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_req && !(ext_req && starve_full)) begin
                    state_d     = BUSY_CORE;
                    lat_d       = LAT_W'(MEM_LAT);
                    wr_d        = core_memwrite;
                    mem_en_d    = 1'b1;
                    mem_we_d    = core_memwrite;
                    mem_addr_d  = core_addr;
                    mem_wdata_d = core_wdata;
                    if (ext_req && !starve_full) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (ext_req) begin
                    state_d     = BUSY_EXT;
                    lat_d       = LAT_W'(MEM_LAT);
                    wr_d        = ext_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ext_we;
                    mem_addr_d  = ext_addr;
                    mem_wdata_d = ext_wdata;
                    ext_gnt_d   = 1'b1;
                    starve_d    = '0;
                end
            end
            BUSY_CORE, BUSY_EXT: begin
                if (lat_q == '0) begin
                    state_d = IDLE;
                    if (state_q == BUSY_CORE) begin
                        core_done_d = 1'b1;
                        if (!wr_q) begin
                            core_rdata_d = mem_rdata;
                        end
                    end else if (!wr_q) begin
                        ext_rdata_d  = mem_rdata;
                        ext_rvalid_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            starve_q     <= '0;
            wr_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
            core_done_q  <= 1'b0;
            ext_gnt_q    <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            starve_q     <= starve_d;
            wr_q         <= wr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
            core_done_q  <= core_done_d;
            ext_gnt_q    <= ext_gnt_d;
            ext_rvalid_q <= ext_rvalid_d;
        end
    end

    assign core_stall = (core_memread | core_memwrite) & ~core_done_q & ~reset;
    assign core_rdata = core_rdata_q;
    assign ext_gnt    = ext_gnt_q;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clk            (clk),
        .reset          (reset),
        .core_stall     (core_stall),
        .ext_gnt        (ext_gnt_q),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_ext_cnt   (stat_ext_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=1, STARVE_MAX=4) with a 1-cycle memory model.
// Statistics checks are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       core_memread, core_memwrite;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       core_stall;
    logic       ext_req, ext_we;
    logic [7:0] ext_addr, ext_wdata, ext_rdata;
    logic       ext_gnt, ext_rvalid;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_stall_cnt, stat_ext_cnt;
`endif

    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_memread  (core_memread),
        .core_memwrite (core_memwrite),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .ext_req       (ext_req),
        .ext_we        (ext_we),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_gnt       (ext_gnt),
        .ext_rvalid    (ext_rvalid),
        .ext_rdata     (ext_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_ext_cnt   (stat_ext_cnt)
`endif
    );

    // Synchronous memory: read data appears one cycle after the mem_en cycle.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Uncontended core access starting in an IDLE cycle; request held through the done cycle.
    task automatic core_access(input logic rd, input logic wr, input logic [7:0] a,
                               input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        core_memread = rd; core_memwrite = wr; core_addr = a; core_wdata = wd;
        #1;
        chk1({tag, "_stall_c0"}, core_stall, 1'b1);
        chk1({tag, "_men_c0"}, mem_en, 1'b0);
        tick();
        chk1({tag, "_men_c1"}, mem_en, 1'b1);
        chk1({tag, "_mwe_c1"}, mem_we, wr);
        chk8({tag, "_maddr_c1"}, mem_addr, a);
        if (wr) chk8({tag, "_mwdata_c1"}, mem_wdata, wd);
        chk1({tag, "_stall_c1"}, core_stall, 1'b1);
        tick();
        chk1({tag, "_men_c2"}, mem_en, 1'b0);
        chk1({tag, "_stall_c2"}, core_stall, 1'b1);
        tick();
        chk1({tag, "_stall_c3"}, core_stall, 1'b0);
        if (!wr) chk8({tag, "_rdata_c3"}, core_rdata, exp_rd);
        tick();
        core_memread = 1'b0; core_memwrite = 1'b0;
        #1;
        chk1({tag, "_no_stale_issue"}, mem_en, 1'b0);
    endtask

    task automatic ext_access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                              input logic [7:0] exp_rd, input string tag);
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = wd;
        #1;
        chk1({tag, "_gnt_e0"}, ext_gnt, 1'b0);
        tick();
        chk1({tag, "_gnt_e1"}, ext_gnt, 1'b1);
        chk1({tag, "_men_e1"}, mem_en, 1'b1);
        chk1({tag, "_mwe_e1"}, mem_we, we);
        chk8({tag, "_maddr_e1"}, mem_addr, a);
        ext_req = 1'b0;
        tick();
        chk1({tag, "_gnt_e2"}, ext_gnt, 1'b0);
        chk1({tag, "_rvalid_e2"}, ext_rvalid, 1'b0);
        tick();
        chk1({tag, "_rvalid_e3"}, ext_rvalid, ~we);
        if (!we) chk8({tag, "_rdata_e3"}, ext_rdata, exp_rd);
        tick();
        chk1({tag, "_rvalid_e4"}, ext_rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        core_memread = 1'b1; core_memwrite = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
        pre_we = 1'b1; pre_addr = 8'h10; pre_data = 8'hA5;
        tick();
        pre_addr = 8'h30; pre_data = 8'h66;
        tick();
        pre_we = 1'b0;
        #1;
        // Reset state, with a core request present to show reset masks the stall.
        chk1("rst_stall", core_stall, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_ext_gnt", ext_gnt, 1'b0);
        chk1("rst_ext_rvalid", ext_rvalid, 1'b0);
        chk8("rst_core_rdata", core_rdata, 8'h00);
        chk8("rst_state", 8'(dut.state_q), 8'(IDLE));
        core_memread = 1'b0;
        reset = 1'b0;
        tick();

        // Core load 0x10 -> 0xA5, three stall cycles.
        core_access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "ld10");

        // External write then core load of the same address.
        ext_access(1'b1, 8'h20, 8'h3C, 8'h00, "extwr20");
        core_access(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, "ld20");

        // External read in flight when a core store arrives.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        tick();
        chk1("xr_gnt", ext_gnt, 1'b1);
        ext_req = 1'b0;
        core_memwrite = 1'b1; core_addr = 8'h40; core_wdata = 8'h77;
        #1;
        chk1("xr_stall_e1", core_stall, 1'b1);
        tick();
        chk1("xr_stall_e2", core_stall, 1'b1);
        chk1("xr_men_e2", mem_en, 1'b0);
        tick();
        chk1("xr_rvalid", ext_rvalid, 1'b1);
        chk8("xr_rdata", ext_rdata, 8'h66);
        chk1("xr_stall_e3", core_stall, 1'b1);
        chk1("xr_men_e3", mem_en, 1'b0);
        tick();
        chk1("st_men", mem_en, 1'b1);
        chk1("st_mwe", mem_we, 1'b1);
        chk8("st_maddr", mem_addr, 8'h40);
        chk8("st_mwdata", mem_wdata, 8'h77);
        chk1("st_rvalid_low", ext_rvalid, 1'b0);
        tick();
        chk1("st_stall_e5", core_stall, 1'b1);
        tick();
        chk1("st_stall_e6", core_stall, 1'b0);
        tick();
        core_memwrite = 1'b0;

        // Read+write together is a write; read it back externally.
        core_access(1'b1, 1'b1, 8'h50, 8'h99, 8'h00, "rw50");
        ext_access(1'b0, 8'h50, 8'h00, 8'h99, "extrd50");

        // Starvation: ext_req present at four core issues, then the external side must win.
        for (int k = 0; k < 4; k++) begin
            core_memread = 1'b1; core_addr = 8'h10;
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
            #1;
            chk1("sv_stall", core_stall, 1'b1);
            tick();
            ext_req = 1'b0;
            chk1("sv_core_issue", mem_en, 1'b1);
            chk1("sv_no_gnt", ext_gnt, 1'b0);
            tick();
            tick();
            chk1("sv_done", core_stall, 1'b0);
            tick();
            core_memread = 1'b0;
        end
        chk8("sv_starve_full", 8'(dut.starve_q), 8'd4);
        core_memread = 1'b1; core_addr = 8'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        #1;
        chk1("sv5_stall", core_stall, 1'b1);
        tick();
        chk1("sv5_gnt", ext_gnt, 1'b1);
        chk8("sv5_maddr", mem_addr, 8'h30);
        chk8("sv5_starve_clr", 8'(dut.starve_q), 8'd0);
        ext_req = 1'b0;
        tick();
        tick();
        chk1("sv5_rvalid", ext_rvalid, 1'b1);
        chk1("sv5_stall_e3", core_stall, 1'b1);
        tick();
        chk1("sv5_core_issue", mem_en, 1'b1);
        chk8("sv5_core_addr", mem_addr, 8'h10);
        tick();
        tick();
        chk1("sv5_core_done", core_stall, 1'b0);
        chk8("sv5_core_rdata", core_rdata, 8'hA5);
        tick();
        core_memread = 1'b0;
        #1;

        // Reset in the mem_en cycle of an external read abandons it.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        tick();
        chk1("rr_gnt", ext_gnt, 1'b1);
        reset = 1'b1;
        ext_req = 1'b0;
        tick();
        chk1("rr_mem_en", mem_en, 1'b0);
        chk1("rr_mem_we", mem_we, 1'b0);
        chk8("rr_mem_addr", mem_addr, 8'h00);
        chk8("rr_mem_wdata", mem_wdata, 8'h00);
        chk1("rr_ext_gnt", ext_gnt, 1'b0);
        chk1("rr_ext_rvalid", ext_rvalid, 1'b0);
        chk8("rr_ext_rdata", ext_rdata, 8'h00);
        chk8("rr_core_rdata", core_rdata, 8'h00);
        chk1("rr_core_stall", core_stall, 1'b0);
        chk8("rr_state", 8'(dut.state_q), 8'(IDLE));
`ifdef MEM_ARB_STATS_EN
        chk16("rr_stat_stall", stat_stall_cnt, 16'd0);
        chk16("rr_stat_ext", stat_ext_cnt, 16'd0);
`endif
        reset = 1'b0;
        tick();
        chk1("rr_no_rvalid_1", ext_rvalid, 1'b0);
        tick();
        chk1("rr_no_rvalid_2", ext_rvalid, 1'b0);
        chk1("rr_idle_men", mem_en, 1'b0);

        // Three core loads and two external accesses from a clean reset.
        core_access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "st_ld1");
        core_access(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C, "st_ld2");
        core_access(1'b1, 1'b0, 8'h50, 8'h00, 8'h99, "st_ld3");
        ext_access(1'b1, 8'h60, 8'h11, 8'h00, "st_xw");
        ext_access(1'b0, 8'h60, 8'h00, 8'h11, "st_xr");
`ifdef MEM_ARB_STATS_EN
        chk16("stat_stall_cnt", stat_stall_cnt, 16'd9);
        chk16("stat_ext_cnt", stat_ext_cnt, 16'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
